// File: rtl/video_timing_pkg.sv
// Shared raster-timing definitions: scheduler states, region-boundary helpers and
// the 640x480@60 default constant set.
package video_timing_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // 640x480@60 defaults
  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;
  localparam int unsigned DefCntW     = 12;

  // Last coordinate of the visible region
  function automatic int unsigned visible_end(input int unsigned visible);
    return visible - 1;
  endfunction

  // First coordinate of the sync pulse
  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned front);
    return visible + front;
  endfunction

  // Last coordinate of the sync pulse
  function automatic int unsigned sync_end(input int unsigned visible,
                                           input int unsigned front,
                                           input int unsigned sync);
    return visible + front + sync - 1;
  endfunction

  // Total positions per line (or lines per frame)
  function automatic int unsigned total(input int unsigned visible,
                                        input int unsigned front,
                                        input int unsigned sync,
                                        input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/video_sync_scheduler_if.sv
// Upstream pixel stream: one 24-bit {B,G,R} pixel per ready/valid transfer.
interface video_sync_scheduler_if;

  logic [23:0] Pixel_Data;
  logic        Pixel_Valid;
  logic        Pixel_Ready;

  // Pixel source (frame reader or line FIFO)
  modport master (
    output Pixel_Data,
    output Pixel_Valid,
    input  Pixel_Ready
  );

  // Scheduler side
  modport slave (
    input  Pixel_Data,
    input  Pixel_Valid,
    output Pixel_Ready
  );

endinterface

// File: rtl/video_hv_counter.sv
// Horizontal/vertical raster position counters. clear holds both at zero and
// wins over run; run advances h every cycle and v on each h wrap.
module video_hv_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = total(DefHVisible, DefHFront, DefHSync, DefHBack),
  parameter int unsigned V_TOTAL = total(DefVVisible, DefVFront, DefVSync, DefVBack),
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             line_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] HLast = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast = CNT_W'(V_TOTAL - 1);

  assign line_end  = (h == HLast);
  assign frame_end = line_end && (v == VLast);

  // Position update: hold at origin while cleared, otherwise step through the raster
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (clear) begin
      h <= '0;
      v <= '0;
    end else if (run) begin
      if (line_end) begin
        h <= '0;
        v <= frame_end ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_sync_scheduler.sv
// Raster timing generator and pixel scheduler. Produces HD/VD/DEN from the h/v
// counters, pulls one pixel per visible slot and presents it aligned with the
// syncs one cycle after the counter position that produced it.
module video_sync_scheduler
  import video_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DefHVisible,
  parameter int unsigned H_FRONT   = DefHFront,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BACK    = DefHBack,
  parameter int unsigned V_VISIBLE = DefVVisible,
  parameter int unsigned V_FRONT   = DefVFront,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BACK    = DefVBack,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic                   Video_CLK,
  input  logic                   Video_RESET,
  input  logic                   Enable,
  video_sync_scheduler_if.slave  pix,
  input  logic                   Underflow_Clear,
  output logic                   Video_HD,
  output logic                   Video_VD,
  output logic                   Video_DEN,
  output logic [23:0]            Video_RGB_Out,
  output logic [CNT_W-1:0]       Pixel_X,
  output logic [CNT_W-1:0]       Pixel_Y,
  output logic                   Frame_Start,
  output logic                   Underflow,
  output logic                   Busy
);

  localparam int unsigned HTotal = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] HVisEnd    = CNT_W'(visible_end(H_VISIBLE));
  localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(sync_start(H_VISIBLE, H_FRONT));
  localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
  localparam logic [CNT_W-1:0] VVisEnd    = CNT_W'(visible_end(V_VISIBLE));
  localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(sync_start(V_VISIBLE, V_FRONT));
  localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

  // Counters must be able to reach the last position of the raster
  if ((longint'(HTotal) - 1 >= (longint'(1) << CNT_W)) ||
      (longint'(VTotal) - 1 >= (longint'(1) << CNT_W))) begin : g_width_check
    $error("CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  state_e           state_q;
  logic [CNT_W-1:0] h, v;
  logic             line_end, frame_end;
  logic             active, cnt_clear;
  logic             h_vis, v_vis, h_sync, v_sync;
  logic             pixel_ready, slot_empty;
  logic             unused_line_end;

  assign active    = (state_q != StIdle);
  assign cnt_clear = ~active;

  video_hv_counter #(
    .H_TOTAL (HTotal),
    .V_TOTAL (VTotal),
    .CNT_W   (CNT_W)
  ) u_hv_counter (
    .clk       (Video_CLK),
    .rst       (Video_RESET),
    .run       (active),
    .clear     (cnt_clear),
    .h         (h),
    .v         (v),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  assign unused_line_end = line_end;

  assign h_vis  = (h <= HVisEnd);
  assign v_vis  = (v <= VVisEnd);
  assign h_sync = active && (h >= HSyncStart) && (h <= HSyncEnd);
  assign v_sync = active && (v >= VSyncStart) && (v <= VSyncEnd);

  // Timing never stalls: a visible slot with no valid data is emitted as black
  assign pixel_ready     = active && h_vis && v_vis;
  assign slot_empty      = pixel_ready && !pix.Pixel_Valid;
  assign pix.Pixel_Ready = pixel_ready;
  assign Busy            = active;

  // Run control: Enable may stop output only at the last position of a frame
  always_ff @(posedge Video_CLK or posedge Video_RESET) begin
    if (Video_RESET) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (Enable) state_q <= StRun;
        StRun:   if (!Enable) state_q <= frame_end ? StIdle : StDrain;
        StDrain: begin
          if (Enable)         state_q <= StRun;
          else if (frame_end) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Registered video outputs, all from the same counter position
  always_ff @(posedge Video_CLK or posedge Video_RESET) begin
    if (Video_RESET) begin
      Video_HD      <= ~SYNC_POL;
      Video_VD      <= ~SYNC_POL;
      Video_DEN     <= 1'b0;
      Video_RGB_Out <= '0;
      Pixel_X       <= '0;
      Pixel_Y       <= '0;
      Frame_Start   <= 1'b0;
    end else begin
      Video_HD      <= h_sync ? SYNC_POL : ~SYNC_POL;
      Video_VD      <= v_sync ? SYNC_POL : ~SYNC_POL;
      Video_DEN     <= pixel_ready;
      Video_RGB_Out <= (pixel_ready && pix.Pixel_Valid) ? pix.Pixel_Data : '0;
      Frame_Start   <= active && (h == '0) && (v == '0);
      if (pixel_ready) begin
        Pixel_X <= h;
        Pixel_Y <= v;
      end
    end
  end

  // Sticky underflow flag; a new empty slot beats a simultaneous clear
  always_ff @(posedge Video_CLK or posedge Video_RESET) begin
    if (Video_RESET) begin
      Underflow <= 1'b0;
    end else if (slot_empty) begin
      Underflow <= 1'b1;
    end else if (Underflow_Clear) begin
      Underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_sync_scheduler.sv
// Bench for video_sync_scheduler on a small 8x6 raster plus a default 640x480
// instance for line-level timing. The reference model tracks only "running" and
// a linear frame position; h/v, regions and expected outputs are derived from it.
module tb_video_sync_scheduler;

  localparam int HT  = 8;
  localparam int VT  = 6;
  localparam int FT  = HT * VT;
  localparam int HV  = 4;
  localparam int VV  = 3;
  localparam int HSS = 5;
  localparam int HSE = 6;
  localparam int VSL = 4;

  logic        clk;
  logic        rst;
  logic        en, clr;
  logic        hd, vd, den, fs, uf, busy;
  logic [23:0] rgb;
  logic [11:0] px, py;

  logic        en_d;
  logic        hd_d, vd_d, den_d, fs_d, uf_d, busy_d;
  logic [23:0] rgb_d;
  logic [11:0] x_d, y_d;

  video_sync_scheduler_if pif ();
  video_sync_scheduler_if dif ();

  video_sync_scheduler #(
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_POL  (1'b0), .CNT_W (12)
  ) dut (
    .Video_CLK       (clk),
    .Video_RESET     (rst),
    .Enable          (en),
    .pix             (pif),
    .Underflow_Clear (clr),
    .Video_HD        (hd),
    .Video_VD        (vd),
    .Video_DEN       (den),
    .Video_RGB_Out   (rgb),
    .Pixel_X         (px),
    .Pixel_Y         (py),
    .Frame_Start     (fs),
    .Underflow       (uf),
    .Busy            (busy)
  );

  video_sync_scheduler dut_def (
    .Video_CLK       (clk),
    .Video_RESET     (rst),
    .Enable          (en_d),
    .pix             (dif),
    .Underflow_Clear (1'b0),
    .Video_HD        (hd_d),
    .Video_VD        (vd_d),
    .Video_DEN       (den_d),
    .Video_RGB_Out   (rgb_d),
    .Pixel_X         (x_d),
    .Pixel_Y         (y_d),
    .Frame_Start     (fs_d),
    .Underflow       (uf_d),
    .Busy            (busy_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  // Reference model state
  bit          running;
  int          pos;
  int          next_pix;
  int          lx, ly;
  bit          m_uf;
  logic [52:0] exp_vec, obs_vec;
  logic [1:0]  exp_rb, obs_rb;

  function automatic logic [52:0] observe();
    return {hd, vd, den, fs, uf, px, py, rgb};
  endfunction

  task automatic model_reset();
    running = 1'b0;
    pos     = 0;
    m_uf    = 1'b0;
    lx      = 0;
    ly      = 0;
  endtask

  // One clock: drive inputs, sample ready/busy before the edge, outputs after it
  task automatic drive(input bit e, input bit val, input bit c);
    int          h, v;
    bit          vis;
    logic [23:0] d;
    h   = pos % HT;
    v   = pos / HT;
    vis = running && (h < HV) && (v < VV);
    d   = val ? 24'(next_pix) : 24'($urandom);
    en  = e;
    clr = c;
    pif.Pixel_Valid = val;
    pif.Pixel_Data  = d;
    #1;
    exp_rb = {vis, running};
    obs_rb = {pif.Pixel_Ready, busy};
    @(posedge clk);
    #1;
    if (vis) begin
      lx = h;
      ly = v;
    end
    if (vis && !val) m_uf = 1'b1;
    else if (c)      m_uf = 1'b0;
    exp_vec = {!(running && h >= HSS && h <= HSE), !(running && v == VSL), vis,
               running && pos == 0, m_uf, 12'(lx), 12'(ly), (vis && val) ? d : 24'h0};
    obs_vec = observe();
    if (vis && val) next_pix++;
    if (!running) begin
      if (e) begin
        running = 1'b1;
        pos     = 0;
      end
    end else if (pos == FT - 1 && !e) begin
      running = 1'b0;
      pos     = 0;
    end else begin
      pos = (pos + 1) % FT;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; en_d = 1'b0;
    pif.Pixel_Valid = 1'b0; pif.Pixel_Data = '0;
    dif.Pixel_Valid = 1'b1; dif.Pixel_Data = 24'hABCDEF;
    #12;
    tests_run++;
    if (observe() !== {1'b1, 1'b1, 51'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h want=%h", observe(), {1'b1, 1'b1, 51'b0});
    end
    tests_run++;
    if ({pif.Pixel_Ready, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready_busy got=%b want=00", {pif.Pixel_Ready, busy});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    int n_den, n_hd, n_vd, n_fs;
    n_den = 0; n_hd = 0; n_vd = 0; n_fs = 0;
    next_pix = 1;
    for (int k = 0; k < FT + 1; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL stream k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      tests_run++;
      if (obs_rb !== exp_rb) begin
        tests_failed++;
        $display("FAIL stream_ready k=%0d got=%b want=%b", k, obs_rb, exp_rb);
      end
      if (k >= 1) begin
        if (den) n_den++;
        if (!hd) n_hd++;
        if (!vd) n_vd++;
        if (fs)  n_fs++;
      end
    end
    tests_run++;
    if (n_den != HV * VV) begin
      tests_failed++; $display("FAIL stream_den_count got=%0d want=%0d", n_den, HV * VV);
    end
    tests_run++;
    if (n_hd != 2 * VT) begin
      tests_failed++; $display("FAIL stream_hd_low got=%0d want=%0d", n_hd, 2 * VT);
    end
    tests_run++;
    if (n_vd != HT) begin
      tests_failed++; $display("FAIL stream_vd_low got=%0d want=%0d", n_vd, HT);
    end
    tests_run++;
    if (n_fs != 1) begin
      tests_failed++; $display("FAIL stream_frame_start got=%0d want=1", n_fs);
    end
  endtask

  task automatic test_underflow();
    for (int k = 0; k < FT && pos != 0; k++) drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < FT; k++) begin
      drive(1'b1, pos != 2, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL underflow k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
    end
    tests_run++;
    if (uf !== 1'b1) begin
      tests_failed++; $display("FAIL underflow_sticky got=%b want=1", uf);
    end
  endtask

  task automatic test_underflow_clear();
    for (int k = 0; k < FT && !(pos % HT < HV - 1 && pos / HT < VV); k++)
      drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    tests_run++;
    if (uf !== 1'b0 || obs_vec !== exp_vec) begin
      tests_failed++; $display("FAIL clear_alone got uf=%b want uf=0", uf);
    end
    drive(1'b1, 1'b0, 1'b1);
    tests_run++;
    if (uf !== 1'b1 || obs_vec !== exp_vec) begin
      tests_failed++; $display("FAIL clear_vs_set got uf=%b want uf=1", uf);
    end
    drive(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_drain();
    int fs_idx, start_pos;
    for (int k = 0; k < FT && pos != 10; k++) drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2 * FT && running; k++) begin
      drive(1'b0, 1'b1, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec || obs_rb !== exp_rb) begin
        tests_failed++;
        $display("FAIL drain k=%0d got=%h/%b want=%h/%b", k, obs_vec, obs_rb, exp_vec, exp_rb);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0);
      tests_run++;
      if ({hd, vd, den, obs_rb} !== 5'b11000) begin
        tests_failed++;
        $display("FAIL idle_levels k=%0d got=%b want=11000", k, {hd, vd, den, obs_rb});
      end
    end
    for (int k = 0; k < 2 * FT && !(running && pos == 20); k++) drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 1'b0);
    start_pos = pos;
    fs_idx = -1;
    for (int k = 0; k < FT; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec || obs_rb !== exp_rb) begin
        tests_failed++;
        $display("FAIL redrain k=%0d got=%h/%b want=%h/%b", k, obs_vec, obs_rb, exp_vec, exp_rb);
      end
      if (fs && fs_idx < 0) fs_idx = k;
    end
    tests_run++;
    if (fs_idx != FT - start_pos) begin
      tests_failed++; $display("FAIL reenable_gap got=%0d want=%0d", fs_idx, FT - start_pos);
    end
  endtask

  task automatic test_reset_mid();
    int saved;
    for (int k = 0; k < 2 * FT && pos != 9; k++) drive(1'b1, 1'b1, 1'b0);
    saved = next_pix;
    rst = 1'b1;
    #2;
    tests_run++;
    if (observe() !== {1'b1, 1'b1, 51'b0} || {pif.Pixel_Ready, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mid got=%h rb=%b want=%h rb=00", observe(),
               {pif.Pixel_Ready, busy}, {1'b1, 1'b1, 51'b0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL after_reset k=%0d got=%h want=%h", k, obs_vec, exp_vec);
      end
      if (k == 1) begin
        tests_run++;
        if ({fs, den, rgb} !== {2'b11, 24'(saved)}) begin
          tests_failed++;
          $display("FAIL restart_first_pixel got=%h want=%h", {fs, den, rgb},
                   {2'b11, 24'(saved)});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4 * FT; k++) begin
      drive(($urandom % 16) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0);
      tests_run++;
      if (obs_vec !== exp_vec || obs_rb !== exp_rb) begin
        tests_failed++;
        $display("FAIL random k=%0d got=%h/%b want=%h/%b", k, obs_vec, obs_rb, exp_vec, exp_rb);
      end
    end
  endtask

  task automatic test_default_timing();
    int         fall1, fall2, low_len, den_cnt, fs_at;
    logic       prev_hd;
    logic [11:0] last_x;
    fall1 = -1; fall2 = -1; low_len = 0; den_cnt = 0; fs_at = -1; last_x = '0;
    en_d = 1'b1;
    prev_hd = hd_d;
    for (int c = 0; c < 1800; c++) begin
      @(posedge clk);
      #1;
      if (fs_d && fs_at < 0) fs_at = c;
      if (fs_at >= 0 && c < fs_at + 800 && den_d) begin
        den_cnt++;
        last_x = x_d;
      end
      if (prev_hd && !hd_d) begin
        if (fall1 < 0) fall1 = c;
        else if (fall2 < 0) fall2 = c;
      end
      if (!hd_d && fall1 >= 0 && fall2 < 0) low_len++;
      prev_hd = hd_d;
    end
    en_d = 1'b0;
    tests_run++;
    if (fs_at < 0 || fall2 < 0 || fall2 - fall1 != 800) begin
      tests_failed++;
      $display("FAIL default_line_len got=%0d want=800 (fs_at=%0d)", fall2 - fall1, fs_at);
    end
    tests_run++;
    if (low_len != 96) begin
      tests_failed++; $display("FAIL default_hsync_width got=%0d want=96", low_len);
    end
    tests_run++;
    if (den_cnt != 640) begin
      tests_failed++; $display("FAIL default_den_per_line got=%0d want=640", den_cnt);
    end
    tests_run++;
    if (last_x !== 12'd639) begin
      tests_failed++; $display("FAIL default_last_x got=%0d want=639", last_x);
    end
    tests_run++;
    if (fall1 - fs_at != 656) begin
      tests_failed++; $display("FAIL default_hsync_start got=%0d want=656", fall1 - fs_at);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    next_pix     = 1;
    model_reset();
    test_reset();
    test_stream();
    test_underflow();
    test_underflow_clear();
    test_drain();
    test_reset_mid();
    test_random();
    test_default_timing();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
